// File: rtl/pcie_phy_sram_boot_loader.sv
`default_nettype none
// ============================================================================
// Module   : pcie_phy_sram_boot_loader
// Purpose  : Copies a firmware image from the external PHY ROM into the PHY
//            SRAM after start and keeps a running checksum. Once the copy is
//            done, PHY SRAM accesses are passed straight through to the memory.
//            Until then, PHY accesses are blocked.
// Ports    : phy0_sram_clk / phy0_sram_rst_n - clock, sync active-low reset
//            ld_start, ld_bypass           - start a load / skip the copy
//            rom_addr, rom_rd_data         - ROM read port (1-cycle latency)
//            phy_sram_*                    - PHY-side SRAM port
//            mem_sram_*                    - single-port SRAM port
//            ld_busy, sram_ext_ld_done     - LOAD / DONE status
//            ld_checksum                   - mod-2^WD_RAM sum of loaded words
// Revision : 1.0 - initial release
// ============================================================================
module pcie_phy_sram_boot_loader #(
    parameter int WD_RAM     = 16,
    parameter int PW_RAM     = 15,
    parameter int DP_RAM     = 32768,
    parameter int LOAD_WORDS = 32768
) (
    input  logic              phy0_sram_clk,
    input  logic              phy0_sram_rst_n,
    input  logic              ld_start,
    input  logic              ld_bypass,
    output logic [PW_RAM-1:0] rom_addr,
    input  logic [WD_RAM-1:0] rom_rd_data,
    input  logic [PW_RAM-1:0] phy_sram_addr,
    input  logic              phy_sram_rd_en,
    input  logic              phy_sram_wr_en,
    input  logic [WD_RAM-1:0] phy_sram_wr_data,
    output logic [WD_RAM-1:0] phy_sram_rd_data,
    output logic [PW_RAM-1:0] mem_sram_addr,
    output logic              mem_sram_rd_en,
    output logic              mem_sram_wr_en,
    output logic [WD_RAM-1:0] mem_sram_wr_data,
    input  logic [WD_RAM-1:0] mem_sram_rd_data,
    output logic              ld_busy,
    output logic              sram_ext_ld_done,
    output logic [WD_RAM-1:0] ld_checksum
);

    // Out-of-range word counts are clamped into 1..DP_RAM.
    localparam int c_words = (LOAD_WORDS < 1)      ? 1 :
                             (LOAD_WORDS > DP_RAM) ? DP_RAM : LOAD_WORDS;
    // One extra bit so a full-depth load can be counted without wrapping.
    localparam logic [PW_RAM:0] c_load_words = c_words[PW_RAM:0];
    localparam logic [PW_RAM:0] c_cnt_one    = {{PW_RAM{1'b0}}, 1'b1};

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_LOAD = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t            r_state;
    logic [PW_RAM:0]   r_cnt;       // ROM reads issued so far
    logic [PW_RAM-1:0] r_rom_addr;
    logic              r_rd_vld;    // rom_addr carries a valid read this cycle
    logic              r_wr_en;     // ROM data for r_wr_addr arrives this cycle
    logic [PW_RAM-1:0] r_wr_addr;
    logic [WD_RAM-1:0] r_checksum;
    logic              r_busy;
    logic              r_done;

    always_ff @(posedge phy0_sram_clk) begin
        if (!phy0_sram_rst_n) begin
            r_state    <= S_IDLE;
            r_cnt      <= '0;
            r_rom_addr <= '0;
            r_rd_vld   <= 1'b0;
            r_wr_en    <= 1'b0;
            r_wr_addr  <= '0;
            r_checksum <= '0;
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE, S_DONE: begin
                    if (ld_start) begin
                        if (!ld_bypass) begin
                            // First ROM read goes out in the cycle after start.
                            r_state    <= S_LOAD;
                            r_busy     <= 1'b1;
                            r_done     <= 1'b0;
                            r_checksum <= '0;
                            r_rom_addr <= '0;
                            r_rd_vld   <= 1'b1;
                            r_cnt      <= c_cnt_one;
                        end else begin
                            // Bypass keeps whatever checksum is already held.
                            r_state <= S_DONE;
                            r_done  <= 1'b1;
                        end
                    end
                end
                S_LOAD: begin
                    // Address is delayed one stage to meet the ROM data.
                    r_wr_en   <= r_rd_vld;
                    r_wr_addr <= r_rom_addr;
                    if (r_wr_en) begin
                        r_checksum <= r_checksum + rom_rd_data;
                    end
                    if (r_cnt < c_load_words) begin
                        r_rom_addr <= r_cnt[PW_RAM-1:0];
                        r_cnt      <= r_cnt + c_cnt_one;
                        r_rd_vld   <= 1'b1;
                    end else begin
                        r_rom_addr <= '0;
                        r_rd_vld   <= 1'b0;
                    end
                    // Write in flight with no read behind it is the last one.
                    if (r_wr_en && !r_rd_vld) begin
                        r_state <= S_DONE;
                        r_busy  <= 1'b0;
                        r_done  <= 1'b1;
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    // Loader owns the memory port until DONE; afterwards the PHY drives it.
    // The loader port is forced to zero whenever no loader write is active.
    assign mem_sram_addr    = r_done ? phy_sram_addr    :
                              (r_wr_en ? r_wr_addr : '0);
    assign mem_sram_rd_en   = r_done ? phy_sram_rd_en   : 1'b0;
    assign mem_sram_wr_en   = r_done ? phy_sram_wr_en   : r_wr_en;
    assign mem_sram_wr_data = r_done ? phy_sram_wr_data :
                              (r_wr_en ? rom_rd_data : '0);
    assign phy_sram_rd_data = r_done ? mem_sram_rd_data : '0;

    assign rom_addr         = r_rom_addr;
    assign ld_busy          = r_busy;
    assign sram_ext_ld_done = r_done;
    assign ld_checksum      = r_checksum;

endmodule
`default_nettype wire

// File: tb/tb_pcie_phy_sram_boot_loader.sv
`default_nettype none
// ============================================================================
// Module   : tb_pcie_phy_sram_boot_loader
// Purpose  : Self-checking bench for pcie_phy_sram_boot_loader. A small
//            instance (8 words) is checked every cycle against a cycle-count
//            reference model; a full-depth instance checks a 32768-word load.
// Revision : 1.0 - initial release
// ============================================================================
module tb_pcie_phy_sram_boot_loader;

    localparam int N = 8;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        ld_start = 1'b0, ld_bypass = 1'b0;
    logic [14:0] rom_addr;
    logic [15:0] rom_rd_data = 16'h0;
    logic [14:0] phy_addr = '0;
    logic        phy_rd_en = 1'b0, phy_wr_en = 1'b0;
    logic [15:0] phy_wr_data = '0;
    logic [15:0] phy_rd_data;
    logic [14:0] mem_addr;
    logic        mem_rd_en, mem_wr_en;
    logic [15:0] mem_wr_data;
    logic [15:0] mem_rd_data = 16'h0;
    logic        busy, done;
    logic [15:0] cks;

    // Full-depth instance signals
    logic        ld_start_f = 1'b0;
    logic [14:0] rom_addr_f;
    logic [15:0] rom_data_f = 16'hFFFF;
    logic [14:0] zero_addr_f = '0;
    logic        zero_bit_f = 1'b0;
    logic [15:0] zero_data_f = '0;
    logic [15:0] phy_rd_data_f;
    logic [14:0] mem_addr_f;
    logic        mem_rd_en_f, mem_wr_en_f;
    logic [15:0] mem_wr_data_f;
    logic        busy_f, done_f;
    logic [15:0] cks_f;

    logic [15:0] rom [N];
    logic [15:0] mem [32768];

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    pcie_phy_sram_boot_loader #(
        .WD_RAM(16), .PW_RAM(15), .DP_RAM(32768), .LOAD_WORDS(N)
    ) dut (
        .phy0_sram_clk(clk), .phy0_sram_rst_n(rst_n),
        .ld_start(ld_start), .ld_bypass(ld_bypass),
        .rom_addr(rom_addr), .rom_rd_data(rom_rd_data),
        .phy_sram_addr(phy_addr), .phy_sram_rd_en(phy_rd_en),
        .phy_sram_wr_en(phy_wr_en), .phy_sram_wr_data(phy_wr_data),
        .phy_sram_rd_data(phy_rd_data),
        .mem_sram_addr(mem_addr), .mem_sram_rd_en(mem_rd_en),
        .mem_sram_wr_en(mem_wr_en), .mem_sram_wr_data(mem_wr_data),
        .mem_sram_rd_data(mem_rd_data),
        .ld_busy(busy), .sram_ext_ld_done(done), .ld_checksum(cks)
    );

    pcie_phy_sram_boot_loader dut_full (
        .phy0_sram_clk(clk), .phy0_sram_rst_n(rst_n),
        .ld_start(ld_start_f), .ld_bypass(zero_bit_f),
        .rom_addr(rom_addr_f), .rom_rd_data(rom_data_f),
        .phy_sram_addr(zero_addr_f), .phy_sram_rd_en(zero_bit_f),
        .phy_sram_wr_en(zero_bit_f), .phy_sram_wr_data(zero_data_f),
        .phy_sram_rd_data(phy_rd_data_f),
        .mem_sram_addr(mem_addr_f), .mem_sram_rd_en(mem_rd_en_f),
        .mem_sram_wr_en(mem_wr_en_f), .mem_sram_wr_data(mem_wr_data_f),
        .mem_sram_rd_data(zero_data_f),
        .ld_busy(busy_f), .sram_ext_ld_done(done_f), .ld_checksum(cks_f)
    );

    // Environment: ROM and SRAM with 1-cycle read latency, write wins.
    always @(posedge clk) rom_rd_data <= (rom_addr < N) ? rom[rom_addr] : 16'h0;
    always @(posedge clk) begin
        if (mem_wr_en) mem[mem_addr] <= mem_wr_data;
        else if (mem_rd_en) mem_rd_data <= mem[mem_addr];
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    function automatic logic [15:0] rom_sum(input int cnt);
        logic [15:0] s = 16'h0;
        for (int i = 0; i < cnt; i++) s = s + rom[i];
        return s;
    endfunction

    // Reference model: mode plus the cycle index since the start edge.
    int          m_state = 0;     // 0 idle, 1 loading, 2 done
    int          m_d = 0;         // cycle number within a load (1..N+1)
    logic [15:0] m_final = 16'h0;
    bit          m_valid = 1'b0;

    always @(posedge clk) begin
        if (!rst_n) begin
            m_state = 0; m_d = 0; m_final = 16'h0; m_valid = 1'b1;
        end else begin
            case (m_state)
                0: if (ld_start) begin
                    if (ld_bypass) begin m_state = 2; m_final = 16'h0; end
                    else begin m_state = 1; m_d = 1; end
                end
                1: begin
                    m_d++;
                    if (m_d == N + 2) begin m_state = 2; m_final = rom_sum(N); end
                end
                default: if (ld_start && !ld_bypass) begin m_state = 1; m_d = 1; end
            endcase
        end
    end

    always @(negedge clk) begin
        logic [14:0] e_rom, e_addr;
        logic        e_busy, e_done, e_ren, e_wen;
        logic [15:0] e_wd, e_prd, e_cks;
        if (m_valid) begin
            e_rom = '0; e_addr = '0; e_busy = 0; e_done = 0; e_ren = 0; e_wen = 0;
            e_wd = '0; e_prd = '0; e_cks = '0;
            if (m_state == 1) begin
                e_busy = 1'b1;
                if (m_d <= N) e_rom = 15'(m_d - 1);
                if (m_d >= 2) begin
                    e_wen = 1'b1; e_addr = 15'(m_d - 2); e_wd = rom[m_d - 2];
                end
                if (m_d >= 3) e_cks = rom_sum(m_d - 2);
            end else if (m_state == 2) begin
                e_done = 1'b1; e_addr = phy_addr; e_ren = phy_rd_en; e_wen = phy_wr_en;
                e_wd = phy_wr_data; e_prd = mem_rd_data; e_cks = m_final;
            end
            chk("m_rom_addr", rom_addr, e_rom);
            chk("m_busy", busy, e_busy);
            chk("m_done", done, e_done);
            chk("m_mem_addr", mem_addr, e_addr);
            chk("m_mem_rd_en", mem_rd_en, e_ren);
            chk("m_mem_wr_en", mem_wr_en, e_wen);
            chk("m_mem_wr_data", mem_wr_data, e_wd);
            chk("m_phy_rd_data", phy_rd_data, e_prd);
            chk("m_checksum", cks, e_cks);
        end
    end

    // Full-depth instance monitor
    int          f_nw = 0, f_addr_err = 0, f_rd_err = 0, f_rises = 0;
    logic [14:0] f_last = '0;
    logic        f_done_q = 1'b0;
    always @(negedge clk) begin
        if (mem_wr_en_f === 1'b1) begin
            if (mem_addr_f !== f_nw[14:0] || mem_wr_data_f !== 16'hFFFF) f_addr_err++;
            f_last = mem_addr_f;
            f_nw++;
        end
        if (mem_rd_en_f === 1'b1 && busy_f === 1'b1) f_rd_err++;
        if (done_f === 1'b1 && f_done_q === 1'b0) f_rises++;
        f_done_q = (done_f === 1'b1);
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic rand_phy();
        phy_addr    = 15'($urandom);
        phy_rd_en   = 1'($urandom);
        phy_wr_en   = 1'($urandom);
        phy_wr_data = 16'($urandom);
    endtask

    initial begin
        int t;
        for (int i = 0; i < N; i++) rom[i] = 16'(i + 1);
        for (int i = 0; i < 32768; i++) mem[i] = 16'h0;
        repeat (3) cyc();
        chk("rst_rom_addr", rom_addr, 0);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_checksum", cks, 0);
        rst_n = 1'b1;
        cyc();

        // Load 1: ROM[i]=i+1, PHY activity must stay blocked
        ld_start = 1'b1; ld_bypass = 1'b0;
        cyc();                                   // cycle 1
        ld_start = 1'b0; rand_phy();
        chk("c1_rom_addr", rom_addr, 0);
        chk("c1_busy", busy, 1);
        cyc(); rand_phy();                       // cycle 2
        chk("c2_wr_en", mem_wr_en, 1);
        chk("c2_wr_addr", mem_addr, 0);
        chk("c2_wr_data", mem_wr_data, 16'h0001);
        chk("c2_phy_rd_data", phy_rd_data, 0);
        repeat (7) begin cyc(); rand_phy(); end  // cycle 9
        chk("c9_wr_addr", mem_addr, 7);
        chk("c9_wr_data", mem_wr_data, 16'h0008);
        chk("c9_busy", busy, 1);
        chk("c9_done", done, 0);
        cyc();                                   // cycle 10
        phy_rd_en = 0; phy_wr_en = 0;
        chk("c10_done", done, 1);
        chk("c10_busy", busy, 0);
        chk("c10_checksum", cks, 16'h0024);

        // PHY pass-through write then read
        phy_wr_en = 1; phy_rd_en = 0; phy_addr = 15'h0003; phy_wr_data = 16'hBEEF;
        #1;
        chk("pt_wr_en", mem_wr_en, 1);
        chk("pt_wr_addr", mem_addr, 15'h0003);
        chk("pt_wr_data", mem_wr_data, 16'hBEEF);
        cyc();
        phy_wr_en = 0; phy_rd_en = 1;
        #1;
        chk("pt_rd_en", mem_rd_en, 1);
        cyc();
        phy_rd_en = 0;
        chk("pt_rd_data", phy_rd_data, 16'hBEEF);

        // Bypass from IDLE
        rst_n = 1'b0; cyc(); rst_n = 1'b1; cyc();
        ld_start = 1'b1; ld_bypass = 1'b1;
        cyc();
        ld_start = 1'b0; ld_bypass = 1'b0;
        chk("byp_done", done, 1);
        chk("byp_checksum", cks, 0);
        chk("byp_busy", busy, 0);

        // Reload from DONE, reset at cycle 4
        ld_start = 1'b1;
        cyc(); ld_start = 1'b0;
        repeat (3) begin cyc(); rand_phy(); end
        rst_n = 1'b0;
        cyc(); rand_phy();
        chk("abort_rom_addr", rom_addr, 0);
        chk("abort_busy", busy, 0);
        chk("abort_done", done, 0);
        chk("abort_wr_en", mem_wr_en, 0);
        chk("abort_wr_data", mem_wr_data, 0);
        chk("abort_checksum", cks, 0);
        rst_n = 1'b1;
        cyc();
        ld_start = 1'b1;
        cyc(); ld_start = 1'b0;
        t = 0;
        while (done !== 1'b1 && t < 40) begin cyc(); rand_phy(); t++; end
        chk("reload_done_in_time", done, 1);
        chk("reload_checksum", cks, 16'h0024);

        // Randomized phase with random ROM image
        for (int i = 0; i < N; i++) rom[i] = 16'($urandom);
        for (int i = 0; i < 1500; i++) begin
            cyc();
            rst_n     = ($urandom_range(0, 199) != 0);
            ld_start  = ($urandom_range(0, 9) == 0);
            ld_bypass = ($urandom_range(0, 2) == 0);
            rand_phy();
        end
        cyc();
        rst_n = 1'b1; ld_start = 1'b0; ld_bypass = 1'b0;
        phy_rd_en = 0; phy_wr_en = 0;

        // Full-depth load, ROM all 0xFFFF
        cyc();
        ld_start_f = 1'b1;
        cyc();
        ld_start_f = 1'b0;
        t = 0;
        while (done_f !== 1'b1 && t < 33000) begin cyc(); t++; end
        chk("full_done_in_time", done_f, 1);
        repeat (4) cyc();
        chk("full_writes", f_nw, 32768);
        chk("full_last_addr", f_last, 15'h7FFF);
        chk("full_checksum", cks_f, 16'h8000);
        chk("full_done_rises", f_rises, 1);
        chk("full_addr_errors", f_addr_err, 0);
        chk("full_rd_during_load", f_rd_err, 0);
        chk("full_done_held", done_f, 1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/pcie_phy_sram_boot_loader.md
Name: pcie_phy_sram_boot_loader

Overview:
- Sits directly upstream of the PHY memory top, between the PHY's SRAM port and the single-port PHY SRAM.
- On start, copies a firmware image of LOAD_WORDS words from the external PHY ROM into the SRAM and accumulates a checksum.
- On completion, asserts ext-load-done and passes PHY SRAM accesses straight through to the memory.
- Until load completes, PHY accesses to the SRAM are blocked.

Parameters:
- WD_RAM, 16, SRAM/ROM data width.
- PW_RAM, 15, SRAM/ROM address width.
- DP_RAM, 32768, SRAM depth in words.
- LOAD_WORDS, 32768, number of words copied; 1..DP_RAM.

Ports:
- phy0_sram_clk  in  1  single clock for all logic.
- phy0_sram_rst_n  in  1  synchronous active-low reset.
- ld_start  in  1  level; sampled high in IDLE or DONE starts a load.
- ld_bypass  in  1  sampled with ld_start; when 1, skip copy and go straight to DONE.
- rom_addr  out  PW_RAM  ROM read address; ROM read latency is fixed at 1 cycle.
- rom_rd_data  in  WD_RAM  ROM data, valid 1 cycle after rom_addr.
- phy_sram_addr  in  PW_RAM  PHY-side address.
- phy_sram_rd_en  in  1  PHY-side read enable.
- phy_sram_wr_en  in  1  PHY-side write enable.
- phy_sram_wr_data  in  WD_RAM  PHY-side write data.
- phy_sram_rd_data  out  WD_RAM  PHY-side read data.
- mem_sram_addr  out  PW_RAM  memory address.
- mem_sram_rd_en  out  1  memory read enable.
- mem_sram_wr_en  out  1  memory write enable.
- mem_sram_wr_data  out  WD_RAM  memory write data.
- mem_sram_rd_data  in  WD_RAM  memory read data; 1-cycle latency.
- ld_busy  out  1  high in LOAD.
- sram_ext_ld_done  out  1  high in DONE.
- ld_checksum  out  WD_RAM  modulo-2^WD_RAM sum of all words written in the last load.

Behaviour:
- Reset (phy0_sram_rst_n=0 at a clock edge):
  - FSM to IDLE; word counter, checksum and write pipeline cleared.
  - All outputs 0: rom_addr, mem_* strobes/addr/data, ld_busy, sram_ext_ld_done, ld_checksum, phy_sram_rd_data.
  - Reset during LOAD aborts the copy; a partially written SRAM is acceptable.
- States:
  - IDLE -> LOAD when ld_start=1 and ld_bypass=0.
  - IDLE -> DONE when ld_start=1 and ld_bypass=1; checksum stays 0.
  - LOAD -> DONE after the last write issues.
  - DONE -> LOAD on ld_start=1 with ld_bypass=0 (reload). This clears done and checksum on entry.
  - DONE with ld_start=1 and ld_bypass=1 stays in DONE.
  - ld_start during LOAD is ignored.
- LOAD timing (start sampled at edge 0):
  - Cycles 1..LOAD_WORDS: rom_addr = 0..LOAD_WORDS-1, one per cycle, no stalls.
  - Write pipeline: cycle k+1 drives mem_sram_wr_en=1, mem_sram_addr=k, mem_sram_wr_data=rom_rd_data. Address is registered one stage to align with ROM data.
  - Last write at cycle LOAD_WORDS+1. sram_ext_ld_done=1 and final ld_checksum are visible from cycle LOAD_WORDS+2.
  - ld_busy=1 for cycles 1..LOAD_WORDS+1.
  - Checksum adds each written word at its write edge; carry discarded.
  - mem_sram_rd_en=0 throughout LOAD.
  - rom_addr returns to 0 outside LOAD.
- PHY port outside DONE:
  - PHY rd_en/wr_en are dropped; writes are lost, not queued.
  - phy_sram_rd_data = 0.
- PHY port in DONE:
  - Combinational pass-through: mem_sram_addr/rd_en/wr_en/wr_data = phy_sram_*.
  - phy_sram_rd_data = mem_sram_rd_data; read latency is unchanged at 1 cycle.
- Simultaneous phy_sram_rd_en and wr_en are forwarded as-is; the memory treats this as a write.
- LOAD_WORDS=1:
  - Exactly one write (addr 0) at cycle 2; done at cycle 3.
- Counter is PW_RAM+1 bits so that LOAD_WORDS=DP_RAM terminates without wrap.

Test Plan:
- Reset, then ld_start pulse with ROM[i]=i+1 and LOAD_WORDS=8 -> writes addr 0..7 data 1..8 on cycles 2..9; done at cycle 10; ld_checksum=0x0024; ld_busy high for cycles 1..9.
- After done, PHY writes 0xBEEF to addr 0x0003 then reads it -> mem port mirrors PHY inputs; phy_sram_rd_data=0xBEEF one cycle after the read.
- PHY rd_en/wr_en toggled during LOAD -> no PHY access reaches mem port (only loader writes); phy_sram_rd_data=0.
- ld_start with ld_bypass=1 from IDLE -> DONE next cycle; no mem writes; ld_checksum=0.
- Reset asserted at cycle 4 of an 8-word load -> next cycle all outputs 0 and state IDLE. A new ld_start reloads from addr 0 and gives full checksum 0x0024.
- ROM all 0xFFFF with LOAD_WORDS=DP_RAM -> 32768 writes, last to addr 0x7FFF; checksum=0x8000; counter does not wrap and done asserts once.
